bc_buffer_mw: RTL and testbench

//  Multi-width, multi-bank broadcast buffer between the VLSU load unit and lane0's mini slide unit.

---
 rtl/bc_buffer_mw.sv | 187 ++++++++++++++++++
 tb/tb_bc_buffer_mw.sv | 352 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bc_buffer_mw.sv
// bc_buffer_mw: ring of beat banks between the VLSU load unit and lane0's slide unit.
// Serialises each bank into EW16/32/64 elements and replays it until invalidated.
module bc_buffer_mw #(
  parameter int unsigned NrLanes  = 4,
  parameter int unsigned NrBufs   = 2,
  parameter int unsigned BufDepth = 8,
  parameter int unsigned MaxBlen  = BufDepth * NrLanes * 4,
  localparam int unsigned BlenW   = $clog2(MaxBlen + 1)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     cfg_valid_i,
  input  logic [1:0]               cfg_ew_i,
  input  logic [BlenW-1:0]         cfg_blen_i,
  output logic                     cfg_ready_o,
  input  logic [NrLanes-1:0]       ldu_result_req_i,
  input  logic [NrLanes-1:0][63:0] ldu_result_wdata_i,
  output logic [NrLanes-1:0]       ldu_result_gnt_o,
  output logic [NrLanes-1:0]       ldu_result_final_gnt_o,
  output logic [63:0]              bc_data_o,
  output logic                     bc_data_valid_o,
  input  logic                     bc_data_ready_i,
  output logic                     bc_data_last_o,
  input  logic                     bc_data_invalidate_i
);

  localparam int unsigned LW = $clog2(NrLanes);
  localparam int unsigned PW = (NrBufs > 1) ? $clog2(NrBufs) : 1;
  localparam int unsigned CW = $clog2(BufDepth + 1);
  localparam int unsigned BW = (BufDepth > 1) ? $clog2(BufDepth) : 1;
  localparam int unsigned XW = BlenW + 2;

  typedef logic [NrLanes-1:0][63:0] beat_t;

  beat_t            mem_q [NrBufs][BufDepth];
  logic [1:0]       ew_q;
  logic [BlenW-1:0] blen_q;
  logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]    wcnt_q [NrBufs];
  logic [NrBufs-1:0] loaded_q;
  logic [BlenW-1:0] idx_q;
  logic             valid_q, last_q;
  logic [63:0]      data_q;

  logic [3:0]    lepb;
  logic [XW-1:0] epb_m1, bpb, avail_el, k, cfg_cap;
  logic          gnt, wr_done, byp, inv_ok, can_load, pop_en, is_last, busy;
  logic [BW-1:0] rd_beat;
  logic [LW-1:0] lane;
  logic [1:0]    sub;
  logic [5:0]    shamt;
  logic [63:0]   mask, lane_w, elem;
  beat_t         src;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(NrBufs - 1)) ? '0 : p + PW'(1);
  endfunction

  // log2 of elements per beat: NrLanes*64/EW
  assign lepb   = 4'(LW + 3) - {2'b00, ew_q};
  assign epb_m1 = (XW'(1) << lepb) - XW'(1);
  assign bpb    = (XW'(blen_q) + epb_m1) >> lepb;

  assign gnt     = (&ldu_result_req_i) && !loaded_q[wr_ptr_q]
                && (XW'(wcnt_q[wr_ptr_q]) < bpb);
  assign wr_done = gnt && (XW'(wcnt_q[wr_ptr_q]) + XW'(1) == bpb);
  assign inv_ok  = bc_data_invalidate_i && loaded_q[rd_ptr_q];

  assign ldu_result_gnt_o       = {NrLanes{gnt}};
  assign ldu_result_final_gnt_o = {NrLanes{gnt}};

  // Beat being granted into the read bank is forwarded straight to the output
  assign byp      = gnt && (wr_ptr_q == rd_ptr_q);
  assign avail_el = (XW'(wcnt_q[rd_ptr_q]) + (byp ? XW'(1) : XW'(0))) << lepb;
  assign can_load = XW'(idx_q) < avail_el;
  assign pop_en   = !valid_q || bc_data_ready_i;
  assign is_last  = (idx_q == blen_q - BlenW'(1));

  assign rd_beat = BW'(XW'(idx_q) >> lepb);
  assign k       = XW'(idx_q) & epb_m1;
  assign lane    = LW'(k);
  assign sub     = 2'(k >> LW);
  assign src     = (byp && rd_beat == BW'(wcnt_q[rd_ptr_q]))
                 ? ldu_result_wdata_i : mem_q[rd_ptr_q][rd_beat];

  always_comb begin
    shamt = '0;
    mask  = '1;
    unique case (1'b1)
      (ew_q == 2'b01): begin
        shamt = {sub, 4'b0000};
        mask  = 64'h0000_0000_0000_FFFF;
      end
      (ew_q == 2'b10): begin
        shamt = {sub[0], 5'b00000};
        mask  = 64'h0000_0000_FFFF_FFFF;
      end
      default: ;
    endcase
    lane_w = src[lane];
    elem   = (lane_w >> shamt) & mask;
  end

  always_comb begin
    busy = |loaded_q;
    for (int b = 0; b < NrBufs; b++) begin
      busy = busy || (wcnt_q[b] != '0);
    end
  end

  assign cfg_ready_o = !busy && !valid_q;

  always_ff @(posedge clk_i) begin
    if (gnt) begin
      mem_q[wr_ptr_q][BW'(wcnt_q[wr_ptr_q])] <= ldu_result_wdata_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ew_q     <= 2'b10;
      blen_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      loaded_q <= '0;
      for (int b = 0; b < NrBufs; b++) begin
        wcnt_q[b] <= '0;
      end
    end else begin
      if (cfg_valid_i && cfg_ready_o) begin
        ew_q   <= cfg_ew_i;
        blen_q <= cfg_blen_i;
      end
      for (int b = 0; b < NrBufs; b++) begin
        if (inv_ok && rd_ptr_q == PW'(b)) begin
          loaded_q[b] <= 1'b0;
          wcnt_q[b]   <= '0;
        end else if (gnt && wr_ptr_q == PW'(b)) begin
          wcnt_q[b] <= wcnt_q[b] + CW'(1);
          if (wr_done) loaded_q[b] <= 1'b1;
        end
      end
      if (wr_done) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (inv_ok)  rd_ptr_q <= ptr_inc(rd_ptr_q);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      data_q  <= '0;
    end else if (inv_ok) begin
      idx_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else if (pop_en) begin
      if (can_load) begin
        valid_q <= 1'b1;
        data_q  <= elem;
        last_q  <= is_last;
        idx_q   <= is_last ? '0 : idx_q + BlenW'(1);
      end else begin
        valid_q <= 1'b0;
        last_q  <= 1'b0;
      end
    end
  end

  assign bc_data_o       = data_q;
  assign bc_data_valid_o = valid_q;
  assign bc_data_last_o  = last_q;

  assign cfg_cap = XW'(BufDepth) << (4'(LW + 3) - {2'b00, cfg_ew_i});

  a_cfg_legal: assert property (@(posedge clk_i) disable iff (!rst_ni)
    cfg_valid_i && cfg_ready_o |->
      cfg_ew_i != 2'b00 && cfg_blen_i != '0 && XW'(cfg_blen_i) <= cfg_cap);

  a_inv_loaded: assert property (@(posedge clk_i) disable iff (!rst_ni)
    bc_data_invalidate_i |-> loaded_q[rd_ptr_q]);

  a_wr_inv: assert property (@(posedge clk_i) disable iff (!rst_ni)
    !(gnt && inv_ok && wr_ptr_q == rd_ptr_q));

endmodule

// File: tb/tb_bc_buffer_mw.sv
// Scoreboard bench for bc_buffer_mw: directed beats, expected elements queued,
// a negedge monitor pops and compares on every accepted output element.
module tb_bc_buffer_mw;
  localparam int NL  = 4;
  localparam int NB  = 3;
  localparam int BD  = 8;
  localparam int MB  = BD * NL * 4;
  localparam int BLW = $clog2(MB + 1);

  logic clk = 1'b0;
  logic rst_ni = 1'b0;
  always #5 clk = ~clk;

  logic                cfg_valid;
  logic [1:0]          cfg_ew;
  logic [BLW-1:0]      cfg_blen;
  logic                cfg_ready;
  logic [NL-1:0]       req;
  logic [NL-1:0][63:0] wdata;
  logic [NL-1:0]       gnt, fgnt;
  logic [63:0]         data;
  logic                valid, ready, last, inv;

  bc_buffer_mw #(.NrLanes(NL), .NrBufs(NB), .BufDepth(BD)) dut (
    .clk_i                 (clk),
    .rst_ni                (rst_ni),
    .cfg_valid_i           (cfg_valid),
    .cfg_ew_i              (cfg_ew),
    .cfg_blen_i            (cfg_blen),
    .cfg_ready_o           (cfg_ready),
    .ldu_result_req_i      (req),
    .ldu_result_wdata_i    (wdata),
    .ldu_result_gnt_o      (gnt),
    .ldu_result_final_gnt_o(fgnt),
    .bc_data_o             (data),
    .bc_data_valid_o       (valid),
    .bc_data_ready_i       (ready),
    .bc_data_last_o        (last),
    .bc_data_invalidate_i  (inv)
  );

  typedef struct {
    logic [63:0] d;
    logic        l;
  } exp_t;

  exp_t        exp_q [$];
  int          pop_cyc [$];
  logic [63:0] beats [16][NL];
  int  nchk = 0;
  int  nerr = 0;
  int  cyc  = 0;
  bit  auto_rdy = 1'b1;
  bit  man_rdy  = 1'b0;
  bit  prev_stall = 1'b0;
  int  g0, g1;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    nchk++;
    nerr++;
    $display("FAIL %s: timeout, got no event expected one", name);
  endtask

  function automatic logic [63:0] model(input int bt, input int ewb, input int k);
    logic [63:0] w, m;
    int lane, sub;
    lane = k % NL;
    sub  = k / NL;
    w    = beats[bt][lane];
    m    = (ewb == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << ewb) - 64'd1);
    return (w >> (sub * ewb)) & m;
  endfunction

  task automatic push_bank(input int b0, input int ewb, input int blen,
                           input int count);
    int epb, idx;
    exp_t e;
    epb = NL * 64 / ewb;
    for (int j = 0; j < count; j++) begin
      idx = j % blen;
      e.d = model(b0 + idx / epb, ewb, idx % epb);
      e.l = (idx == blen - 1);
      exp_q.push_back(e);
    end
  endtask

  // Consumer ready: auto mode accepts only while elements are expected
  initial begin
    forever begin
      @(posedge clk);
      #2;
      ready = auto_rdy ? (exp_q.size() != 0) : man_rdy;
    end
  end

  always @(negedge clk) begin
    if (!rst_ni) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall && exp_q.size() != 0) begin
        chk("hold_valid", 64'(valid), 64'd1);
        chk("hold_data", data, exp_q[0].d);
      end
      if (valid && ready && !inv) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_elem", data, 64'hDEAD_DEAD_DEAD_DEAD);
        end else begin
          chk("elem_data", data, exp_q[0].d);
          chk("elem_last", 64'(last), 64'(exp_q[0].l));
          void'(exp_q.pop_front());
          pop_cyc.push_back(cyc);
        end
      end
      prev_stall = valid && !ready && !inv;
    end
  end

  task automatic do_cfg(input logic [1:0] ew, input int blen);
    @(posedge clk);
    #1;
    chk("cfg_ready", 64'(cfg_ready), 64'd1);
    cfg_valid = 1'b1;
    cfg_ew    = ew;
    cfg_blen  = BLW'(blen);
    @(posedge clk);
    #1;
    cfg_valid = 1'b0;
  endtask

  task automatic send_beat(input int b, output int gc);
    int n;
    @(posedge clk);
    #1;
    req = '1;
    for (int l = 0; l < NL; l++) wdata[l] = beats[b][l];
    n = 0;
    gc = -1;
    while (n < 60) begin
      @(negedge clk);
      if (gnt == '1) begin
        gc = cyc;
        chk("final_gnt", 64'(fgnt), 64'hF);
        break;
      end
      n++;
    end
    if (gc < 0) timeout("beat_gnt");
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic invalidate();
    @(posedge clk);
    #1;
    inv = 1'b1;
    @(posedge clk);
    #1;
    inv = 1'b0;
    chk("inv_valid", 64'(valid), 64'd0);
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) timeout(name);
  endtask

  initial begin
    for (int b = 0; b < 16; b++)
      for (int l = 0; l < NL; l++)
        for (int s = 0; s < 4; s++)
          beats[b][l][16*s +: 16] = {4'(s + 1), 8'(b), 4'(l)};
    cfg_valid = 1'b0;
    cfg_ew    = 2'b10;
    cfg_blen  = '0;
    req       = '0;
    wdata     = '0;
    ready     = 1'b0;
    inv       = 1'b0;

    repeat (2) @(negedge clk);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd1);
    chk("rst_valid", 64'(valid), 64'd0);
    chk("rst_gnt", 64'(gnt), 64'd0);
    chk("rst_last", 64'(last), 64'd0);
    chk("rst_data", data, 64'd0);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;

    // EW32 blen16: two beats, one wrap element
    do_cfg(2'b10, 16);
    push_bank(0, 32, 16, 17);
    send_beat(0, g0);
    send_beat(1, g0);
    wait_drain("ew32_drain");
    invalidate();
    @(negedge clk);
    chk("ew32_cfg_ready", 64'(cfg_ready), 64'd1);

    // EW16 blen20: two beats, zero-extended halfwords
    do_cfg(2'b01, 20);
    push_bank(2, 16, 20, 21);
    send_beat(2, g0);
    send_beat(3, g0);
    wait_drain("ew16_drain");
    invalidate();

    // EW64 blen4 with a 5-cycle stall
    auto_rdy = 1'b0;
    man_rdy  = 1'b0;
    do_cfg(2'b11, 4);
    push_bank(4, 64, 4, 5);
    send_beat(4, g0);
    begin
      int n;
      n = 0;
      while (!valid && n < 20) begin
        @(negedge clk);
        n++;
      end
      if (!valid) timeout("ew64_valid");
    end
    repeat (5) @(negedge clk);
    @(posedge clk);
    #1;
    auto_rdy = 1'b1;
    wait_drain("ew64_drain");
    invalidate();

    // Ring full: three one-beat banks, fourth waits for invalidate
    do_cfg(2'b10, 8);
    send_beat(5, g0);
    send_beat(6, g0);
    send_beat(7, g0);
    @(posedge clk);
    #1;
    req = '1;
    for (int l = 0; l < NL; l++) wdata[l] = beats[8][l];
    repeat (4) begin
      @(negedge clk);
      chk("ring_full_gnt", 64'(gnt), 64'd0);
    end
    @(posedge clk);
    #1;
    inv = 1'b1;
    @(negedge clk);
    chk("ring_inv_cycle_gnt", 64'(gnt), 64'd0);
    @(posedge clk);
    #1;
    inv = 1'b0;
    chk("ring_inv_valid", 64'(valid), 64'd0);
    @(negedge clk);
    chk("ring_next_gnt", 64'(gnt), 64'hF);
    @(posedge clk);
    #1;
    req = '0;
    push_bank(6, 32, 8, 8);
    wait_drain("ring_b1");
    invalidate();
    push_bank(7, 32, 8, 8);
    wait_drain("ring_b2");
    invalidate();
    push_bank(8, 32, 8, 8);
    wait_drain("ring_b0");
    invalidate();

    // Streaming read of a partially loaded bank
    do_cfg(2'b10, 16);
    push_bank(9, 32, 16, 16);
    pop_cyc.delete();
    send_beat(9, g0);
    repeat (8) @(posedge clk);
    send_beat(10, g1);
    wait_drain("stream_drain");
    if (pop_cyc.size() >= 9) begin
      chk("stream_first", 64'(pop_cyc[0]), 64'(g0 + 1));
      chk("stream_e7", 64'(pop_cyc[7]), 64'(g0 + 8));
      chk("stream_e8", 64'(pop_cyc[8]), 64'(g1 + 1));
    end else begin
      timeout("stream_pops");
    end

    // Invalidate while the element is being accepted
    @(posedge clk);
    #1;
    auto_rdy = 1'b0;
    man_rdy  = 1'b1;
    inv      = 1'b1;
    @(posedge clk);
    #1;
    inv     = 1'b0;
    man_rdy = 1'b0;
    chk("inv_rdy_valid", 64'(valid), 64'd0);
    @(posedge clk);
    #1;
    auto_rdy = 1'b1;

    // Reset pulse mid-fill
    do_cfg(2'b10, 16);
    send_beat(11, g0);
    repeat (2) @(posedge clk);
    #1;
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(valid), 64'd0);
    chk("mid_rst_cfg_ready", 64'(cfg_ready), 64'd1);
    @(posedge clk);
    #1;
    rst_ni = 1'b1;
    chk("post_rst_data", data, 64'd0);
    chk("post_rst_last", 64'(last), 64'd0);
    req = '1;
    repeat (3) begin
      @(negedge clk);
      chk("post_rst_blen0_gnt", 64'(gnt), 64'd0);
    end
    @(posedge clk);
    #1;
    req = '0;
    do_cfg(2'b10, 8);
    push_bank(12, 32, 8, 9);
    send_beat(12, g0);
    wait_drain("post_rst_drain");

    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end
endmodule
